// File: rtl/multiword_adder_ctrl.sv
// -----------------------------------------------------------------------------
// multiword_adder_ctrl
//
// Purpose:
//   Sequencer for one shared, external 8-bit adder (hybrid_adder_8).
//   - Accepts one add or subtract request of width W = 8*WORDS.
//   - Drives the adder one byte per cycle, least significant byte first.
//   - Registers each slice's carry-out and feeds it to the next slice as
//     its carry-in.
//   - Subtraction is computed as A + ~B + 1.
//
// Parameters:
//   WORDS        number of 8-bit slices per operand (>= 2)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  request valid            start_ready  request accepted when high
//   op_a, op_b   operands (W bits)        sub          0: A+B, 1: A-B
//   res_valid    result valid             res_ready    consumer takes result
//   result       sum / difference (W)     cout         final carry (sub: 1 = no borrow)
//   overflow     two's-complement signed overflow
//   add_a/add_b  byte slices to adder     add_cin      carry-in to adder
//   add_sum      adder sum (comb.)        add_cout     adder carry-out
//   zero         (only with MWADD_ZERO_FLAG_EN) result == 0, registered with cout
//
// Build option:
//   MWADD_ZERO_FLAG_EN  when defined, adds the `zero` output and its logic.
// -----------------------------------------------------------------------------
module multiword_adder_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [8*WORDS-1:0]   op_a,
  input  logic [8*WORDS-1:0]   op_b,
  input  logic                 sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 overflow,
`ifdef MWADD_ZERO_FLAG_EN
  output logic                 zero,
`endif
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_cin,
  input  logic [7:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic               start_ready_q;
  logic               res_valid_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;         // B stored already inverted for subtraction
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [W-1:0]       result_q;
  logic               cout_q;
  logic               overflow_q;

  // Bit offset of the current slice; 8*idx is just idx with three zero LSBs.
  logic [IDX_W+2:0]   base;
  logic               last_slice;
  logic               ovf_d;

  assign base       = {idx_q, 3'b000};
  assign last_slice = (idx_q == IDX_W'(WORDS - 1));

  // Adder inputs are decoded from registered state only, so they drop to
  // zero as soon as reset asserts, without waiting for a clock edge.
  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise any
    // path that skips an assignment infers a latch.
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_q[base +: 8];
      add_b   = b_q[base +: 8];
      add_cin = carry_q;
    end
  end

  // Signed overflow of the top slice: both addends share a sign and the
  // sum's sign differs. add_b already carries the subtract inversion.
  assign ovf_d = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);

`ifdef MWADD_ZERO_FLAG_EN
  // Full result as it will be after the last slice is written, so the zero
  // flag is registered in the same edge as cout.
  logic [W-1:0] result_fin;
  logic         zero_q;

  always_comb begin
    result_fin              = result_q;
    result_fin[base +: 8]   = add_sum;
  end

  assign zero = zero_q;
`endif

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      result_q      <= '0;
      cout_q        <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef MWADD_ZERO_FLAG_EN
      zero_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            a_q           <= op_a;
            b_q           <= sub ? ~op_b : op_b;
            idx_q         <= '0;
            carry_q       <= sub;   // the +1 of two's-complement subtraction
            start_ready_q <= 1'b0;
            state_q       <= S_RUN;
          end
        end

        S_RUN: begin
          result_q[base +: 8] <= add_sum;
          carry_q             <= add_cout;
          if (last_slice) begin
            cout_q      <= add_cout;
            overflow_q  <= ovf_d;
`ifdef MWADD_ZERO_FLAG_EN
            zero_q      <= ~|result_fin;
`endif
            idx_q       <= '0;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        S_DONE: begin
          // start_ready stays low here, forcing one IDLE cycle between ops.
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= S_IDLE;
          end
        end

        default: begin
          start_ready_q <= 1'b1;
          res_valid_q   <= 1'b0;
          state_q       <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multiword_adder_ctrl
//
// Drives multiword_adder_ctrl (WORDS=4) with directed and random requests.
// - A behavioural model of hybrid_adder_8 is connected to the add_* ports.
// - Expected results come from whole-word arithmetic and are queued when a
//   request is accepted.
// - A separate monitor pops an expected result on every result handshake
//   and compares it with the DUT output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multiword_adder_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           sub;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   result;
  logic           cout;
  logic           overflow;
  logic           zero;
  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic           add_cin;
  logic [7:0]     add_sum;
  logic           add_cout;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  // External 8-bit adder model.
  always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  multiword_adder_ctrl #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
`ifdef MWADD_ZERO_FLAG_EN
    .zero        (zero),
`endif
    .add_a       (add_a),
    .add_b       (add_b),
    .add_cin     (add_cin),
    .add_sum     (add_sum),
    .add_cout    (add_cout)
  );

`ifndef MWADD_ZERO_FLAG_EN
  assign zero = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-word reference: signed range test for overflow, unsigned compare
  // for the carry/borrow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t        e;
    longint      sa, sb, rs;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    rs = s ? (sa - sb) : (sa + sb);
    e.r = s ? (a - b) : (a + b);
    e.c = s ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
    e.v = (rs > 64'sd2147483647) || (rs < -64'sd2147483648);
    e.z = (e.r == '0);
    return e;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!start_ready && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_ready_wait", start_ready, 1);
  endtask

  // Issue one request; checks the first RUN cycle's adder drive and,
  // when wait_res is set, the latency to res_valid.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input bit wait_res);
    logic [W-1:0] bx;
    int k;
    wait_idle(200);
    op_a = a; op_b = b; sub = s; start_valid = 1'b1;
    @(posedge clk);
    sb_q.push_back(model(a, b, s));
    #1;
    start_valid = 1'b0;
    op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    bx = s ? ~b : b;
    check("run0_add_a", add_a, a[7:0]);
    check("run0_add_b", add_b, bx[7:0]);
    check("run0_add_cin", add_cin, s);
    check("run_start_ready", start_ready, 0);
    if (wait_res) begin
      k = 1;
      while (k <= 20) begin
        @(posedge clk); #1;
        if (res_valid) break;
        k++;
      end
      check("latency", k, WORDS);
    end
  endtask

  // Monitor: one expected result per handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        check("result_expected", sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("result", result, e.r);
          check("cout", cout, e.c);
          check("overflow", overflow, e.v);
`ifdef MWADD_ZERO_FLAG_EN
          check("zero", zero, e.z);
`endif
        end
      end
    end
  end

  // Random backpressure during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) res_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] snap_r;
    logic         snap_c, snap_v;
    int           n;

    rst_n = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    res_ready = 1'b1;
    #12;
    check("rst_start_ready", start_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_overflow", overflow, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
    issue(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
    issue(32'h0000_0005, 32'h0000_0004, 1'b1, 1'b1);

    // Backpressure: result held, new requests ignored while in DONE.
    wait_idle(50);
    res_ready = 1'b0;
    issue(32'h1234_5678, 32'h0F0F_F0F0, 1'b0, 1'b1);
    snap_r = result; snap_c = cout; snap_v = overflow;
    op_a = 32'hDEAD_BEEF; op_b = 32'h2152_4111; sub = 1'b1; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_res_valid", res_valid, 1);
      check("bp_start_ready", start_ready, 0);
      check("bp_result", result, snap_r);
      check("bp_flags", {cout, overflow}, {snap_c, snap_v});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", start_ready, 1);
    check("bp_idle_valid", res_valid, 0);
    @(posedge clk);
    sb_q.push_back(model(32'hDEAD_BEEF, 32'h2152_4111, 1'b1));
    #1;
    check("bp_accept", start_ready, 0);
    start_valid = 1'b0;
    wait_idle(50);

    // Asynchronous reset in the middle of an op (idx=2).
    issue(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_start_ready", start_ready, 1);
    check("arst_res_valid", res_valid, 0);
    check("arst_add", {add_a, add_b, add_cin}, 0);
    sb_q.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);

    // Random ops with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    rand_ready = 1'b0;
    res_ready = 1'b1;
    check("queue_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
